// File: rtl/box_blur_3x3_pkg.sv
// Shared window geometry and sizing helpers for the 3x3 box blur.
package box_blur_3x3_pkg;
    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;
    // Nine taps need four extra bits so the sum never overflows.
    localparam int SUM_GROW = 4;

    function automatic int col_bits(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/box_blur_3x3_if.sv
// Column-beat input and blurred-pixel output of the box blur.
interface box_blur_3x3_if #(
    parameter int dataWidth = 8
);
    logic [dataWidth-1:0] i_row0;
    logic [dataWidth-1:0] i_row1;
    logic [dataWidth-1:0] i_row2;
    logic                 i_data_valid;
    logic [dataWidth-1:0] o_data;
    logic                 o_data_valid;

    modport master (
        output i_row0, i_row1, i_row2, i_data_valid,
        input  o_data, o_data_valid
    );

    modport slave (
        input  i_row0, i_row1, i_row2, i_data_valid,
        output o_data, o_data_valid
    );
endinterface

// File: rtl/blur_defs.vh
// Reciprocal-multiply constants shared by the blur kernel stages.
// floor(sum * BLUR_RECIP_9 >> BLUR_RECIP_SHIFT) == floor(sum / 9) for 9-tap 8-bit sums.
`ifndef BLUR_DEFS_VH
`define BLUR_DEFS_VH
`define BLUR_RECIP_9     7282
`define BLUR_RECIP_SHIFT 16
`define BLUR_RECIP_BITS  13
`endif

// File: rtl/box_blur_3x3_window3x3.sv
// 3x3 sliding pixel window fed one column per valid beat, with the in-row
// column counter that decides when the window holds three real columns.
module window3x3
    import box_blur_3x3_pkg::*;
#(
    parameter int dataWidth  = 8,
    parameter int imageWidth = 512
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic [dataWidth-1:0]               i_row0,
    input  logic [dataWidth-1:0]               i_row1,
    input  logic [dataWidth-1:0]               i_row2,
    input  logic                               i_data_valid,
    output logic [WIN_TAPS-1:0][dataWidth-1:0] o_pixels,
    output logic                               o_window_complete
);
    localparam int               COL_W          = col_bits(imageWidth);
    localparam logic [COL_W-1:0] COL_LAST       = COL_W'(imageWidth - 1);
    localparam logic [COL_W-1:0] COL_FIRST_FULL = COL_W'(WIN_DIM - 1);

    typedef logic [WIN_DIM-1:0][dataWidth-1:0] column_t;

    // Column 0 is the oldest, column WIN_DIM-1 the newest.
    column_t          win_reg  [WIN_DIM];
    column_t          win_next [WIN_DIM];
    logic [COL_W-1:0] col_reg;
    logic [COL_W-1:0] col_next;
    logic             complete_reg;
    logic             complete_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIN_DIM; gi++) begin : g_col
            if (gi == WIN_DIM - 1) begin : g_newest
                assign win_next[gi] = {i_row2, i_row1, i_row0};
            end else begin : g_older
                assign win_next[gi] = win_reg[gi + 1];
            end
            assign o_pixels[gi*WIN_DIM +: WIN_DIM] = win_reg[gi];
        end
    endgenerate

    always_comb begin
        col_next      = (col_reg == COL_LAST) ? '0 : col_reg + 1'b1;
        // The counter value before the increment is this beat's column index.
        complete_next = i_data_valid && (col_reg >= COL_FIRST_FULL);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                win_reg[c] <= '0;
            end
            col_reg      <= '0;
            complete_reg <= 1'b0;
        end else begin
            if (i_data_valid) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    win_reg[c] <= win_next[c];
                end
                col_reg <= col_next;
            end
            complete_reg <= complete_next;
        end
    end

    assign o_window_complete = complete_reg;
endmodule

// File: rtl/box_blur_3x3.sv
// 3x3 box blur: window stage, registered 9-tap sum, then a registered
// reciprocal multiply that yields floor(sum / 9). No backpressure.
module box_blur_3x3
    import box_blur_3x3_pkg::*;
#(
    parameter int dataWidth  = 8,
    parameter int imageWidth = 512
) (
    input  logic          i_clk,
    input  logic          i_rst,
    box_blur_3x3_if.slave bus
);
`include "blur_defs.vh"

    localparam int                SUM_W  = dataWidth + SUM_GROW;
    localparam int                PROD_W = SUM_W + `BLUR_RECIP_BITS;
    localparam logic [PROD_W-1:0] RECIP  = PROD_W'(`BLUR_RECIP_9);

    logic [WIN_TAPS-1:0][dataWidth-1:0] pixels;
    logic                               window_complete;

    logic [SUM_W-1:0]     sum_next;
    logic [SUM_W-1:0]     sum_reg;
    logic                 sum_valid_reg;
    logic [PROD_W-1:0]    product;
    logic [dataWidth-1:0] data_next;
    logic [dataWidth-1:0] data_reg;
    logic                 data_valid_reg;

    window3x3 #(
        .dataWidth  (dataWidth),
        .imageWidth (imageWidth)
    ) u_window (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_row0            (bus.i_row0),
        .i_row1            (bus.i_row1),
        .i_row2            (bus.i_row2),
        .i_data_valid      (bus.i_data_valid),
        .o_pixels          (pixels),
        .o_window_complete (window_complete)
    );

    always_comb begin
        sum_next = '0;
        for (int i = 0; i < WIN_TAPS; i++) begin
            sum_next = sum_next + SUM_W'(pixels[i]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sum_reg       <= '0;
            sum_valid_reg <= 1'b0;
        end else begin
            sum_reg       <= sum_next;
            sum_valid_reg <= window_complete;
        end
    end

    // Multiply by 2^16/9 and drop the fraction instead of dividing.
    assign product   = PROD_W'(sum_reg) * RECIP;
    assign data_next = dataWidth'(product >> `BLUR_RECIP_SHIFT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            data_valid_reg <= sum_valid_reg;
            if (sum_valid_reg) begin
                data_reg <= data_next;
            end
        end
    end

    assign bus.o_data       = data_reg;
    assign bus.o_data_valid = data_valid_reg;
endmodule

// File: tb/tb_box_blur_3x3.sv
// Scoreboard bench for box_blur_3x3: a row/column model predicts each output
// and its arrival time; a monitor pops and compares every output cycle.
module tb_box_blur_3x3;
    localparam int DW     = 8;
    localparam int IW     = 8;
    localparam int PERIOD = 10;

    logic clk = 1'b0;
    logic rst;
    always #(PERIOD/2) clk = ~clk;

    box_blur_3x3_if #(.dataWidth(DW)) bus ();

    box_blur_3x3 #(
        .dataWidth  (DW),
        .imageWidth (IW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int     data;
        longint due;
    } exp_t;

    exp_t   exp_q[$];
    int     checks    = 0;
    int     failures  = 0;
    int     out_count = 0;
    int     last_out  = 0;
    longint rst_edge  = -1;

    // Reference model state: column index in the row and per-column sums.
    int model_col = 0;
    int col_sum[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input bit v, input int a, input int b, input int c, input bit r);
        int s;
        @(negedge clk);
        bus.i_row0       = DW'(a);
        bus.i_row1       = DW'(b);
        bus.i_row2       = DW'(c);
        bus.i_data_valid = v;
        rst              = r;
        if (r) begin
            model_col = 0;
            col_sum.delete();
            rst_edge = longint'($time) + PERIOD/2;
            // Anything whose output edge is at or after the reset edge is lost.
            while (exp_q.size() > 0 && exp_q[$].due >= longint'($time) + PERIOD)
                void'(exp_q.pop_back());
        end else if (v) begin
            col_sum.push_back(a + b + c);
            if (model_col >= 2) begin
                s = col_sum[$] + col_sum[$-1] + col_sum[$-2];
                exp_q.push_back('{s / 9, longint'($time) + 3*PERIOD});
            end
            model_col = (model_col + 1) % IW;
            if (model_col == 0) col_sum.delete();
        end
    endtask

    task automatic beat(input int a, input int b, input int c);
        drive(1'b1, a, b, c, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0, 0, 1'b0);
    endtask

    task automatic const_row(input int v);
        for (int i = 0; i < IW; i++) beat(v, v, v);
    endtask

    task automatic rand_row(input int max_gap);
        for (int i = 0; i < IW; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            beat($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
    endtask

    // Monitor: every negedge either pops a result or confirms o_data held.
    initial begin : monitor
        exp_t   e;
        int     hold_val  = 0;
        longint hold_time = -1;
        logic [DW-1:0] want;
        forever begin
            @(negedge clk);
            if (rst_edge < longint'($time) && rst_edge > hold_time) begin
                hold_val  = 0;
                hold_time = longint'($time);
            end
            if (bus.o_data_valid === 1'b1) begin
                out_count++;
                last_out = int'(bus.o_data);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got o_data=%0d at t=%0t, expected no pulse",
                             bus.o_data, $time);
                end else begin
                    e    = exp_q.pop_front();
                    want = DW'(e.data);
                    if (bus.o_data !== want || longint'($time) != e.due) begin
                        failures++;
                        $display("FAIL output: got %0d at t=%0t, expected %0d at t=%0d",
                                 bus.o_data, $time, want, e.due);
                    end
                    hold_val  = e.data;
                    hold_time = longint'($time);
                end
            end else begin
                want = DW'(hold_val);
                checks++;
                if (bus.o_data !== want || bus.o_data_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL hold: got o_data=%0d valid=%b at t=%0t, expected %0d valid=0",
                             bus.o_data, bus.o_data_valid, $time, want);
                end
            end
        end
    end

    initial begin : stimulus
        int base;
        rst              = 1'b1;
        bus.i_row0       = '0;
        bus.i_row1       = '0;
        bus.i_row2       = '0;
        bus.i_data_valid = 1'b0;
        repeat (3) drive(1'b0, 0, 0, 0, 1'b1);
        check("reset_data", int'(bus.o_data), 0);
        check("reset_valid", int'(bus.o_data_valid), 0);
        idle(3);

        base = out_count;
        const_row(9);
        idle(5);
        check("row9_count", out_count - base, 6);
        check("row9_value", last_out, 9);

        const_row(255);
        idle(5);
        check("row255_value", last_out, 255);
        const_row(0);
        idle(5);
        check("row0_value", last_out, 0);

        for (int i = 0; i < IW; i++) beat(0, (i == IW-1) ? 8 : 0, 0);
        idle(5);
        check("single8_value", last_out, 0);
        for (int i = 0; i < IW; i++) beat(0, 0, (i == IW-1) ? 9 : 0);
        idle(5);
        check("single9_value", last_out, 1);

        // Ramp with valid toggling; the row is then completed to realign.
        base = out_count;
        for (int i = 1; i <= 4; i++) begin
            beat(10*i, 10*i, 10*i);
            idle(1);
        end
        idle(4);
        check("ramp_count", out_count - base, 2);
        check("ramp_last", last_out, 30);
        for (int i = 0; i < IW - 4; i++) beat(7, 7, 7);
        idle(5);

        base = out_count;
        rand_row(0);
        rand_row(0);
        idle(5);
        check("two_rows_count", out_count - base, 12);

        // Reset mid-row with a valid beat at column 5.
        base = out_count;
        for (int i = 0; i < 5; i++) beat(100, 150, 200);
        drive(1'b1, 50, 50, 50, 1'b1);
        idle(5);
        check("reset_midrow_count", out_count - base, 1);
        check("reset_midrow_data", int'(bus.o_data), 0);
        base = out_count;
        rand_row(0);
        idle(5);
        check("after_reset_count", out_count - base, 6);

        base = out_count;
        for (int r = 0; r < 4; r++) rand_row(2);
        idle(5);
        check("random_rows_count", out_count - base, 24);

        idle(5);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/box_blur_3x3.md
BOX_BLUR_3X3 -- requirements
Module: box_blur_3x3

Interface
REQ-001 SHALL have parameter dataWidth, default 8, pixel width in bits.
REQ-002 SHALL have parameter imageWidth, default 512, pixels per image row.
REQ-003 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_row0  input  dataWidth  pixel from oldest line-buffer row (top).
REQ-006 SHALL have port i_row1  input  dataWidth  pixel from middle row.
REQ-007 SHALL have port i_row2  input  dataWidth  pixel from newest row (bottom).
REQ-008 SHALL have port i_data_valid  input  1  the three row pixels are one valid column beat.
REQ-009 SHALL have port o_data  output  dataWidth  blurred pixel.
REQ-010 SHALL have port o_data_valid  output  1  o_data holds a valid result this cycle.

Function
REQ-011 SHALL hold a 3x3 window, 3 columns x 3 rows; on a valid beat it shifts the window one column and loads {i_row0,i_row1,i_row2} into the newest column; with i_data_valid=0 the window holds.
REQ-012 SHALL keep a column counter 0..imageWidth-1 that increments on each valid beat and wraps from imageWidth-1 to 0; with no valid beat it holds.
REQ-013 SHALL mark a window complete on a valid beat whose counter value is >=2; beats at counter 0 and 1 produce no output, giving imageWidth-2 outputs per row.
REQ-014 SHALL have pipeline stage 1 register the 9-pixel sum, width dataWidth+4 bits with no overflow, plus a valid bit taken from window-complete.
REQ-015 SHALL have pipeline stage 2 register o_data = (sum x 7282) >> 16, which equals floor(sum/9) exactly for all sums 0..2295 at dataWidth=8; product width is sum width + 13 bits.
REQ-016 SHALL register o_data_valid for exactly one cycle per complete window, 3 rising edges after the completing input beat (input edge, sum edge, output edge).
REQ-017 SHALL advance the pipeline every cycle; there is no backpressure, and a gap in i_data_valid only creates gaps in o_data_valid.
REQ-018 SHALL hold o_data at its last value when o_data_valid=0.
REQ-019 SHALL continue windows across valid gaps within a row; after the wrap at the row end, the first two beats of the next row again produce no output.

Reset
REQ-020 SHALL, on i_rst=1 at a rising edge, clear the window, column counter, sum register, both valid bits, and o_data to 0.
REQ-021 SHALL give reset priority over a simultaneous valid beat; that beat is discarded.
REQ-022 SHALL discard results in flight at reset mid-row; no o_data_valid pulse occurs in the 3 cycles after reset deasserts unless new beats arrive.
REQ-023 SHALL treat the first valid beat after reset as column 0.

Structure
REQ-024 SHALL take the reciprocal constant 7282 and shift 16 from shared header blur_defs.vh (`include), so later kernel stages reuse them.
REQ-025 SHALL place the window and column counter in sub-module window3x3, which outputs nine pixels and a window-complete flag; box_blur_3x3 instantiates it and adds the sum/scale pipeline.
REQ-026 SHALL use no memories or vendor primitives; registers only.

Verification
REQ-027 Reset then one row (imageWidth=8) with all pixels 9, continuous valid -> 6 pulses of o_data_valid with o_data=9, the first 3 cycles after beat index 2.
REQ-028 All pixels 255 -> o_data=255 (sum 2295); all pixels 0 -> o_data=0; window of eight 0 and one 8 -> o_data=0; eight 0 and one 9 -> o_data=1.
REQ-029 Ramp columns 10,20,30,40 (all rows equal), valid toggling 1/0 -> outputs 20 then 30, each 3 edges after its completing beat, with o_data_valid low between them.
REQ-030 Two rows (imageWidth=8) back to back -> 12 outputs total, none at column beats 0,1 of row 2, confirming the counter wrap.
REQ-031 i_rst asserted for 1 cycle at column 5 with valid high -> no stale pulse, outputs 0; next row yields 6 correct outputs.
REQ-032 Random pixels and gaps for 4 rows against a reference model of floor(sum/9) -> bit-exact match and exact output count.
